pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/cpu_pkg.sv | 16 +
 rtl/next_pc_calc.sv | 20 ++
 rtl/pc_sequencer.sv | 129 ++++++++++++
 tb/tb_pc_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding and
// reset/step constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_TRAP  = 2'd3
  } state_e;

  localparam logic [31:0] INSTR_RESET  = 32'h0000_0000;
  localparam logic [31:0] RETIRE_RESET = 32'h0000_0000;
  localparam int unsigned PC_STEP      = 4;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential step or taken branch, plus a
// misalignment flag on the selected target. Arithmetic wraps at 2^ADDR_WIDTH.
module next_pc_calc #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] immediate_i,
  input  logic                  take_branch_i,
  output logic [ADDR_WIDTH-1:0] next_pc_o,
  output logic                  misaligned_o
);
  import cpu_pkg::*;

  always_comb begin
    next_pc_o    = take_branch_i ? (pc_i + immediate_i)
                                 : (pc_i + ADDR_WIDTH'(PC_STEP));
    misaligned_o = (next_pc_o[1:0] != 2'b00);
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute sequencer: drives instruction fetch, latches the instruction,
// advances the PC on completion and traps on misaligned targets.
//
// Handshakes: imem_req is a request that holds while in FETCH and not stalled;
// the fetch completes on the rising edge where imem_req and imem_ready are both
// high. exec_done completes an instruction only in EXEC and not stalled.
// stall overrides both.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [ADDR_WIDTH-1:0]  TRAP_VECTOR  = ADDR_WIDTH'(32'h0000_0100)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stall,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  input  logic                  exec_done,
  input  logic                  branch,
  input  logic                  zero,
  input  logic [ADDR_WIDTH-1:0] immediate,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  trap,
  output logic [ADDR_WIDTH-1:0] epc,
  output logic [31:0]           retire_cnt,
  output state_e                state_dbg
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] epc_q, epc_d;
  logic [31:0]           instr_q, instr_d;
  logic [31:0]           retire_q, retire_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  next_misaligned;
  logic                  req_c;
  logic                  trap_c;

  next_pc_calc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_pc (
    .pc_i          (pc_q),
    .immediate_i   (immediate),
    .take_branch_i (branch & zero),
    .next_pc_o     (next_pc),
    .misaligned_o  (next_misaligned)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_VECTOR;
      epc_q         <= '0;
      instr_q       <= INSTR_RESET;
      retire_q      <= RETIRE_RESET;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      instr_q       <= instr_d;
      retire_q      <= retire_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Stall gates every transition, so the whole case sits under !stall.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epc_d         = epc_q;
    instr_d       = instr_q;
    retire_d      = retire_q;
    instr_valid_d = 1'b0;
    req_c         = 1'b0;
    trap_c        = 1'b0;
    if (!stall) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FETCH;
        end
        ST_FETCH: begin
          req_c = 1'b1;
          if (imem_ready) begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            if (next_misaligned) begin
              epc_d   = next_pc;
              state_d = ST_TRAP;
            end else begin
              pc_d     = next_pc;
              retire_d = retire_q + 32'd1;
              state_d  = ST_FETCH;
            end
          end
        end
        ST_TRAP: begin
          trap_c  = 1'b1;
          pc_d    = TRAP_VECTOR;
          state_d = ST_FETCH;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign imem_req    = req_c;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign epc         = epc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign retire_cnt  = retire_q;
  assign trap        = trap_c;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: inputs change on the falling edge, outputs
// are compared on the following falling edge.
module tb_pc_sequencer;
  import cpu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic        branch;
  logic        zero;
  logic [31:0] immediate;
  logic [31:0] pc;
  logic        trap;
  logic [31:0] epc;
  logic [31:0] retire_cnt;
  state_e      state_dbg;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .ADDR_WIDTH   (32),
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0100)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .branch      (branch),
    .zero        (zero),
    .immediate   (immediate),
    .pc          (pc),
    .trap        (trap),
    .epc         (epc),
    .retire_cnt  (retire_cnt),
    .state_dbg   (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: from a falling edge in FETCH, deliver one instruction and complete
  // it; returns on the falling edge after completion.
  task automatic run_instr(input logic [31:0] word, input logic br, input logic zr,
                           input logic [31:0] imm);
    imem_ready = 1'b1; imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0; exec_done = 1'b1; branch = br; zero = zr; immediate = imm;
    @(negedge clk);
    exec_done = 1'b0; branch = 1'b0; zero = 1'b0; immediate = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; stall = 1'b0; imem_ready = 1'b0; imem_rdata = '0;
    exec_done = 1'b0; branch = 1'b0; zero = 1'b0; immediate = '0;
    repeat (3) @(negedge clk);
    checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", state_dbg, ST_IDLE); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", pc); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem_req); end
    checks++; if ({instr_valid, trap} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b exp 00", {instr_valid, trap}); end
    checks++; if ({instr, epc, retire_cnt} !== 96'h0) begin errors++; $display("FAIL reset_regs got %h exp 0", {instr, epc, retire_cnt}); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (state_dbg !== ST_FETCH) begin errors++; $display("FAIL idle_to_fetch got %0d exp %0d", state_dbg, ST_FETCH); end
  endtask

  // Ready arrives after two wait cycles: address held for three fetch cycles.
  task automatic test_fetch_latency();
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL fetch_hold%0d got req=%b addr=%h exp req=1 addr=0", i, imem_req, imem_addr); end
      if (i == 2) begin imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
      @(negedge clk);
    end
    imem_ready = 1'b0;
    checks++; if (state_dbg !== ST_EXEC || instr !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fetch_latch got st=%0d instr=%h exp st=2 instr=deadbeef", state_dbg, instr); end
    checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL exec_entry got iv=%b req=%b exp iv=1 req=0", instr_valid, imem_req); end
    // imem_ready in EXEC must be ignored.
    imem_ready = 1'b1; imem_rdata = 32'h1111_1111;
    @(negedge clk);
    imem_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0 || instr !== 32'hDEAD_BEEF || state_dbg !== ST_EXEC) begin errors++; $display("FAIL exec_hold got iv=%b instr=%h st=%0d exp iv=0 instr=deadbeef st=2", instr_valid, instr, state_dbg); end
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    checks++; if (pc !== 32'h4 || retire_cnt !== 32'd1 || state_dbg !== ST_FETCH) begin errors++; $display("FAIL first_retire got pc=%h rc=%0d st=%0d exp pc=4 rc=1 st=1", pc, retire_cnt, state_dbg); end
  endtask

  task automatic test_branch_back();
    for (int i = 0; i < 3; i++) run_instr(32'h0000_0013 + i, 1'b0, 1'b0, 32'h0);
    checks++; if (pc !== 32'h10 || retire_cnt !== 32'd4) begin errors++; $display("FAIL seq_pc got pc=%h rc=%0d exp pc=10 rc=4", pc, retire_cnt); end
    run_instr(32'h0000_0063, 1'b1, 1'b1, 32'hFFFF_FFF8);
    checks++; if (pc !== 32'h8 || retire_cnt !== 32'd5 || trap !== 1'b0) begin errors++; $display("FAIL branch_back got pc=%h rc=%0d trap=%b exp pc=8 rc=5 trap=0", pc, retire_cnt, trap); end
    // branch without zero is not taken
    run_instr(32'h0000_0063, 1'b1, 1'b0, 32'h40);
    checks++; if (pc !== 32'hC || retire_cnt !== 32'd6) begin errors++; $display("FAIL branch_not_taken got pc=%h rc=%0d exp pc=c rc=6", pc, retire_cnt); end
  endtask

  task automatic test_trap();
    run_instr(32'h0000_0013, 1'b0, 1'b0, 32'h0);
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL pre_trap_pc got %h exp 10", pc); end
    imem_ready = 1'b1; imem_rdata = 32'h0000_0063;
    @(negedge clk);
    imem_ready = 1'b0; exec_done = 1'b1; branch = 1'b1; zero = 1'b1; immediate = 32'h6;
    @(negedge clk);
    // exec_done stays high through TRAP; it must be ignored there.
    branch = 1'b0; zero = 1'b0; immediate = '0;
    checks++; if (state_dbg !== ST_TRAP || trap !== 1'b1) begin errors++; $display("FAIL trap_enter got st=%0d trap=%b exp st=3 trap=1", state_dbg, trap); end
    checks++; if (epc !== 32'h16 || pc !== 32'h10 || retire_cnt !== 32'd7) begin errors++; $display("FAIL trap_regs got epc=%h pc=%h rc=%0d exp epc=16 pc=10 rc=7", epc, pc, retire_cnt); end
    @(negedge clk);
    exec_done = 1'b0;
    checks++; if (state_dbg !== ST_FETCH || trap !== 1'b0 || pc !== 32'h100 || retire_cnt !== 32'd7) begin errors++; $display("FAIL trap_exit got st=%0d trap=%b pc=%h rc=%0d exp st=1 trap=0 pc=100 rc=7", state_dbg, trap, pc, retire_cnt); end
  endtask

  task automatic test_stall();
    imem_ready = 1'b1; imem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    imem_ready = 1'b0; stall = 1'b1; exec_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (state_dbg !== ST_EXEC || pc !== 32'h100 || imem_req !== 1'b0 || instr_valid !== 1'b0 || retire_cnt !== 32'd7) begin errors++; $display("FAIL stall_exec%0d got st=%0d pc=%h req=%b iv=%b rc=%0d exp st=2 pc=100 req=0 iv=0 rc=7", i, state_dbg, pc, imem_req, instr_valid, retire_cnt); end
    end
    stall = 1'b0;
    @(negedge clk);
    exec_done = 1'b0;
    checks++; if (state_dbg !== ST_FETCH || pc !== 32'h104 || retire_cnt !== 32'd8) begin errors++; $display("FAIL stall_release got st=%0d pc=%h rc=%0d exp st=1 pc=104 rc=8", state_dbg, pc, retire_cnt); end
    stall = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h5555_AAAA;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_fetch_req got %b exp 0", imem_req); end
    @(negedge clk);
    checks++; if (state_dbg !== ST_FETCH || instr !== 32'hCAFE_0001) begin errors++; $display("FAIL stall_fetch got st=%0d instr=%h exp st=1 instr=cafe0001", state_dbg, instr); end
    stall = 1'b0; imem_ready = 1'b0;
  endtask

  task automatic test_wrap();
    run_instr(32'h0000_0063, 1'b1, 1'b1, 32'hFFFF_FEF8);
    checks++; if (pc !== 32'hFFFF_FFFC || retire_cnt !== 32'd9) begin errors++; $display("FAIL to_top got pc=%h rc=%0d exp pc=fffffffc rc=9", pc, retire_cnt); end
    run_instr(32'h0000_0013, 1'b0, 1'b0, 32'h0);
    checks++; if (pc !== 32'h0 || trap !== 1'b0 || state_dbg !== ST_FETCH || retire_cnt !== 32'd10) begin errors++; $display("FAIL pc_wrap got pc=%h trap=%b st=%0d rc=%0d exp pc=0 trap=0 st=1 rc=10", pc, trap, state_dbg, retire_cnt); end
  endtask

  task automatic test_reset_mid_fetch();
    run_instr(32'h0BAD_F00D, 1'b0, 1'b0, 32'h0);
    checks++; if (instr !== 32'h0BAD_F00D || imem_req !== 1'b1) begin errors++; $display("FAIL pre_reset got instr=%h req=%b exp instr=0badf00d req=1", instr, imem_req); end
    imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    #1 reset_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || pc !== 32'h0 || instr !== 32'h0 || state_dbg !== ST_IDLE || retire_cnt !== 32'd0) begin errors++; $display("FAIL async_reset got req=%b pc=%h instr=%h st=%0d rc=%0d exp req=0 pc=0 instr=0 st=0 rc=0", imem_req, pc, instr, state_dbg, retire_cnt); end
    @(negedge clk);
    imem_ready = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (state_dbg !== ST_FETCH || instr !== 32'h0) begin errors++; $display("FAIL post_reset got st=%0d instr=%h exp st=1 instr=0", state_dbg, instr); end
  endtask

  initial begin
    test_reset();
    test_fetch_latency();
    test_branch_back();
    test_trap();
    test_stall();
    test_wrap();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
